// File: rtl/sparc_rf16x81_fifo_ctl_pkg.sv
// Shared constants for the 16x81 register-file FIFO slice: geometry and the
// static tie-off values the parent applies to the rf macro.
package sparc_rf16x81_fifo_ctl_pkg;

  localparam int unsigned RF16_AW    = 4;
  localparam int unsigned RF16_DEPTH = 16;
  localparam int unsigned RF16_WIDTH = 81;

  localparam logic       RF16_HOLD        = 1'b0;
  localparam logic       RF16_SCAN_EN     = 1'b0;
  localparam logic       RF16_TESTMUX_SEL = 1'b0;
  localparam logic [4:0] RF16_MARGIN      = 5'b10101;

endpackage

// File: rtl/sparc_rf16_skid2.sv
// Two-entry valid/ready output buffer; the head is always driven from a register.
module sparc_rf16_skid2 #(
  parameter int unsigned WIDTH = 81
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             load, pop;

  assign out_vld  = (cnt_q != 2'd0);
  assign out_data = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;

  // Caller guarantees no load when full unless the head pops in the same cycle.
  assign load = in_vld & ~flush;
  assign pop  = out_vld & out_rdy & ~flush;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ load;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_q + {1'b0, load} - {1'b0, pop};
    end
  end

  always_ff @(posedge rclk) begin
    if (load) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/sparc_rf16x81_fifo_ctl.sv
// Runs a 16x81 two-port rf macro as a FIFO: pointers, occupancy, rf strobes
// and a 2-entry skid buffer on the read side.
module sparc_rf16x81_fifo_ctl
  import sparc_rf16x81_fifo_ctl_pkg::*;
#(
  parameter int unsigned WIDTH = RF16_WIDTH,
  parameter int unsigned DEPTH = RF16_DEPTH,
  parameter int unsigned AW    = RF16_AW
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_rdy,
  output logic             rf_csn_wr,
  output logic [AW-1:0]    rf_wr_a,
  output logic [WIDTH-1:0] rf_di,
  output logic             rf_csn_rd,
  output logic [AW-1:0]    rf_rd_a,
  input  logic [WIDTH-1:0] rf_do,
  output logic [AW:0]      occ
);

  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   occ_q, occ_d, vis_q, vis_d;
  logic          push_rdy_q, rd_inflight_q;
  logic          live, push_fire, pop_fire, rd_go;
  logic [1:0]    skid_cnt;
  logic [2:0]    skid_load;

  // Strobes are held off while reset or flush is asserted.
  assign live      = ~reset & ~flush;
  assign push_fire = push_vld & push_rdy_q & live;
  assign pop_fire  = pop_vld & pop_rdy & live;

  // Only read when the word can land in the skid, counting the one in flight.
  assign skid_load = {1'b0, skid_cnt} + {2'b0, rd_inflight_q} - {2'b0, pop_fire};
  assign rd_go     = live & (vis_q != '0) & (skid_load < 3'd2);

  // A write at edge E is readable from the cycle after E, so vis rises with the push.
  always_comb begin
    occ_d = occ_q + (AW+1)'(push_fire) - (AW+1)'(rd_go);
    vis_d = vis_q + (AW+1)'(push_fire) - (AW+1)'(rd_go);
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      wp_q          <= '0;
      rp_q          <= '0;
      occ_q         <= '0;
      vis_q         <= '0;
      push_rdy_q    <= 1'b1;
      rd_inflight_q <= 1'b0;
    end else if (flush) begin
      wp_q          <= '0;
      rp_q          <= '0;
      occ_q         <= '0;
      vis_q         <= '0;
      push_rdy_q    <= 1'b1;
      rd_inflight_q <= 1'b0;
    end else begin
      wp_q          <= wp_q + AW'(push_fire);
      rp_q          <= rp_q + AW'(rd_go);
      occ_q         <= occ_d;
      vis_q         <= vis_d;
      push_rdy_q    <= (occ_d != (AW+1)'(DEPTH));
      rd_inflight_q <= rd_go;
    end
  end

  sparc_rf16_skid2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .rclk     (rclk),
    .reset    (reset),
    .flush    (flush),
    .in_vld   (rd_inflight_q),
    .in_data  (rf_do),
    .out_vld  (pop_vld),
    .out_data (pop_data),
    .out_rdy  (pop_rdy),
    .cnt      (skid_cnt)
  );

  assign push_rdy  = push_rdy_q;
  assign rf_csn_wr = ~push_fire;
  assign rf_wr_a   = wp_q;
  assign rf_di     = push_data;
  assign rf_csn_rd = ~rd_go;
  assign rf_rd_a   = rp_q;
  assign occ       = occ_q;

  a_no_wr_when_full: assert property (@(posedge rclk) disable iff (reset)
    !((occ_q == (AW+1)'(DEPTH)) && !rf_csn_wr));
  a_no_rd_when_empty: assert property (@(posedge rclk) disable iff (reset)
    !(rd_go && (vis_q == '0)));
  a_skid_bound: assert property (@(posedge rclk) disable iff (reset)
    (({1'b0, skid_cnt} + {2'b0, rd_inflight_q}) <= 3'd2));

endmodule

// File: tb/tb_sparc_rf16x81_fifo_ctl.sv
// Randomised bench: queue-level FIFO model plus an rf macro model, checked every cycle.
module tb_sparc_rf16x81_fifo_ctl;

  localparam int W = 81;

  logic          rclk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          push_vld = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          push_rdy;
  logic          pop_vld;
  logic [W-1:0]  pop_data;
  logic          pop_rdy = 1'b0;
  logic          rf_csn_wr;
  logic [3:0]    rf_wr_a;
  logic [W-1:0]  rf_di;
  logic          rf_csn_rd;
  logic [3:0]    rf_rd_a;
  logic [W-1:0]  rf_do = '1;
  logic [4:0]    occ;

  sparc_rf16x81_fifo_ctl dut (
    .rclk      (rclk),
    .reset     (reset),
    .flush     (flush),
    .push_vld  (push_vld),
    .push_data (push_data),
    .push_rdy  (push_rdy),
    .pop_vld   (pop_vld),
    .pop_data  (pop_data),
    .pop_rdy   (pop_rdy),
    .rf_csn_wr (rf_csn_wr),
    .rf_wr_a   (rf_wr_a),
    .rf_di     (rf_di),
    .rf_csn_rd (rf_csn_rd),
    .rf_rd_a   (rf_rd_a),
    .rf_do     (rf_do),
    .occ       (occ)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: rf contents, one in-flight word, and the skid as queues.
  logic [W-1:0] rf_q[$];
  logic [W-1:0] skid_q[$];
  int           m_infl = 0;
  logic [W-1:0] m_infl_data = '0;
  logic         m_push_rdy = 1'b1;
  int           m_wp = 0;
  int           m_rp = 0;

  // rf macro model driven by the DUT's actual strobes.
  logic [W-1:0] rf_mem [16];
  logic         rf_rd_pend = 1'b0;
  logic [W-1:0] rf_rd_word = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic pv, input logic [W-1:0] pd,
                      input logic pr, output logic fired, output logic popped,
                      output logic [W-1:0] pval);
    logic         e_pop_vld, e_push_fire, e_pop_fire, e_rd_go;
    logic [W-1:0] e_pop_data;
    logic         nx_pend;
    logic [W-1:0] nx_word;
    @(negedge rclk);
    reset     = rst;
    flush     = fl;
    push_vld  = pv;
    push_data = pd;
    pop_rdy   = pr;
    rf_do     = rf_rd_pend ? rf_rd_word : '1;
    #1;
    e_pop_vld   = !rst && (skid_q.size() > 0);
    e_pop_data  = (skid_q.size() > 0) ? skid_q[0] : '0;
    e_push_fire = !rst && !fl && pv && m_push_rdy;
    e_pop_fire  = !rst && !fl && e_pop_vld && pr;
    e_rd_go     = !rst && !fl && (rf_q.size() > 0) &&
                  ((skid_q.size() + m_infl - (e_pop_fire ? 1 : 0)) < 2);

    chk("pop_vld", pop_vld, e_pop_vld);
    if (e_pop_vld) chk("pop_data", pop_data, e_pop_data);
    chk("push_rdy", push_rdy, rst ? 1'b1 : m_push_rdy);
    chk("occ", occ, rst ? 0 : rf_q.size());
    chk("rf_csn_wr", rf_csn_wr, !e_push_fire);
    chk("rf_csn_rd", rf_csn_rd, !e_rd_go);
    if (e_push_fire) begin
      chk("rf_wr_a", rf_wr_a, m_wp);
      chk("rf_di", rf_di, pd);
    end
    if (e_rd_go) chk("rf_rd_a", rf_rd_a, m_rp);

    nx_pend = 1'b0;
    nx_word = '1;
    if (rf_csn_rd === 1'b0) begin
      nx_pend = 1'b1;
      nx_word = rf_mem[rf_rd_a];
    end
    if (rf_csn_wr === 1'b0) rf_mem[rf_wr_a] = rf_di;
    rf_rd_pend = nx_pend;
    rf_rd_word = nx_word;

    if (rst || fl) begin
      rf_q.delete();
      skid_q.delete();
      m_infl = 0;
      m_push_rdy = 1'b1;
      m_wp = 0;
      m_rp = 0;
    end else begin
      if (e_pop_fire) void'(skid_q.pop_front());
      if (m_infl != 0) skid_q.push_back(m_infl_data);
      m_infl = e_rd_go ? 1 : 0;
      if (e_rd_go) begin
        m_infl_data = rf_q.pop_front();
        m_rp = (m_rp + 1) % 16;
      end
      if (e_push_fire) begin
        rf_q.push_back(pd);
        m_wp = (m_wp + 1) % 16;
      end
      m_push_rdy = (rf_q.size() != 16);
    end
    fired  = e_push_fire;
    popped = e_pop_fire;
    pval   = e_pop_data;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  logic         f, p;
  logic [W-1:0] pv_w;
  logic [W-1:0] sb[$];
  logic [W-1:0] x_word;

  initial begin
    x_word = 81'h1_2345_6789_ABCD_EF01_2345;

    // Reset state
    step(1, 0, 0, '0, 0, f, p, pv_w);
    step(1, 0, 1, '0, 1, f, p, pv_w);
    chk("rst_push_rdy", push_rdy, 1);
    chk("rst_csn_wr", rf_csn_wr, 1);
    chk("rst_pop_vld", pop_vld, 0);

    // Single push, latency 3, visible exactly one cycle
    step(0, 0, 1, x_word, 1, f, p, pv_w);
    chk("single_fire", f, 1);
    step(0, 0, 0, '0, 1, f, p, pv_w);
    chk("single_rd_csn", rf_csn_rd, 0);
    chk("single_rd_a", rf_rd_a, 0);
    step(0, 0, 0, '0, 1, f, p, pv_w);
    chk("single_c2_vld", pop_vld, 0);
    step(0, 0, 0, '0, 1, f, p, pv_w);
    chk("single_c3_vld", pop_vld, 1);
    chk("single_c3_data", pop_data, x_word);
    step(0, 0, 0, '0, 1, f, p, pv_w);
    chk("single_c4_vld", pop_vld, 0);

    // Fill 18 with pop_rdy low
    for (int i = 0; i < 18; i++) begin
      int budget = 0;
      f = 0;
      while (!f && budget < 50) begin
        step(0, 0, 1, W'(i), 0, f, p, pv_w);
        budget++;
      end
      if (!f) chk("fill_timeout", 0, 1);
    end
    step(0, 0, 0, '0, 0, f, p, pv_w);
    step(0, 0, 0, '0, 0, f, p, pv_w);
    chk("fill_occ", occ, 16);
    chk("fill_push_rdy", push_rdy, 0);
    chk("fill_head", pop_data, 0);

    // Simultaneous edge at full: blocked now, accepted next cycle
    step(0, 0, 1, W'(100), 1, f, p, pv_w);
    chk("edge_blocked_csn", rf_csn_wr, 1);
    chk("edge_blocked_occ", occ, 16);
    chk("edge_pop0", pv_w, 0);
    step(0, 0, 1, W'(100), 1, f, p, pv_w);
    chk("edge_accept_csn", rf_csn_wr, 0);
    chk("edge_pop1", pv_w, 1);

    // Drain: 2..17 then 100, one per cycle
    begin
      int got = 2;
      int cyc = 0;
      int bubbles = 0;
      while (got < 19 && cyc < 60) begin
        step(0, 0, 0, '0, 1, f, p, pv_w);
        cyc++;
        if (p) begin
          chk("drain_order", pv_w, (got < 18) ? W'(got) : W'(100));
          got++;
        end else begin
          bubbles++;
        end
      end
      chk("drain_count", got, 19);
      chk("drain_bubbles", bubbles, 0);
    end

    // Random wrap traffic with scoreboard
    begin
      int pushed = 0;
      int popped_n = 0;
      int cyc = 0;
      logic [W-1:0] d;
      while ((pushed < 40 || popped_n < 40) && cyc < 2000) begin
        d = rnd_word();
        step(0, 0, (pushed < 40) && ($urandom_range(3) != 0), d, $urandom_range(1) == 1,
             f, p, pv_w);
        cyc++;
        if (f) begin
          sb.push_back(d);
          pushed++;
        end
        if (p) begin
          if (sb.size() == 0) chk("wrap_underflow", 1, 0);
          else chk("wrap_sb", pv_w, sb.pop_front());
          popped_n++;
        end
      end
      chk("wrap_done", popped_n, 40);
    end

    // Flush with one word in skid and one in flight
    step(1, 0, 0, '0, 0, f, p, pv_w);
    step(0, 0, 1, W'(81'hA), 0, f, p, pv_w);
    step(0, 0, 1, W'(81'hB), 0, f, p, pv_w);
    step(0, 0, 1, W'(81'hC), 0, f, p, pv_w);
    step(0, 1, 1, W'(81'hD), 0, f, p, pv_w);
    chk("flush_pre_vld", pop_vld, 1);
    chk("flush_csn_wr", rf_csn_wr, 1);
    step(0, 0, 0, '0, 1, f, p, pv_w);
    chk("flush_post_vld", pop_vld, 0);
    chk("flush_post_occ", occ, 0);
    step(0, 0, 0, '0, 1, f, p, pv_w);
    chk("flush_discard", pop_vld, 0);

    // Reset mid-stream with occ=7
    for (int i = 0; i < 9; i++) step(0, 0, 1, W'(i + 200), 0, f, p, pv_w);
    step(0, 0, 0, '0, 0, f, p, pv_w);
    chk("pre_rst_occ", occ, 7);
    step(1, 0, 1, W'(300), 1, f, p, pv_w);
    chk("midrst_pop_vld", pop_vld, 0);
    chk("midrst_csn_wr", rf_csn_wr, 1);
    chk("midrst_csn_rd", rf_csn_rd, 1);
    chk("midrst_push_rdy", push_rdy, 1);
    chk("midrst_occ", occ, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, f, p, pv_w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
